// File: rtl/rca_pkg.sv
// Shared types for the pipelined ripple-carry add/subtract unit.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rca_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/rca_slice.sv
// Combinational SEG-bit ripple-carry slice; also exposes the carry into its MSB.
// Latency: zero (purely combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
module rca_slice #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           msb_cin
);

    always_comb begin : ripple
        logic [SEG:0] c;
        c       = '0;
        s       = '0;
        c[0]    = cin;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout    = c[SEG];
        msb_cin = c[SEG-1];
    end

endmodule

// File: rtl/rca_pipe_addsub.sv
// Streaming WIDTH-bit add/subtract, ripple carry cut into STAGES registered slices.
// Latency: result valid STAGES-1 cycles after the acceptance edge; one beat/cycle.
// Backpressure: whole pipe freezes while the output holds an unaccepted beat.
module rca_pipe_addsub
    import rca_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             advance;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Per-stage registers; operands are carried whole so every slice reads its own bits.
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] res_q [STAGES];
    logic             c_q   [STAGES];
    logic             msb_c_q;

    logic [SEG-1:0]   sl_a  [STAGES];
    logic [SEG-1:0]   sl_b  [STAGES];
    logic [SEG-1:0]   sl_s  [STAGES];
    logic             sl_ci [STAGES];
    logic             sl_co [STAGES];
    logic             sl_mc [STAGES];

    // Subtraction is a + ~b + ~borrow, so the inversion happens once at the input.
    assign is_sub = (op == OP_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign c_eff  = is_sub ? ~cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == 0) begin : g_head
            assign sl_a[k]  = a[SEG-1:0];
            assign sl_b[k]  = b_eff[SEG-1:0];
            assign sl_ci[k] = c_eff;
        end else begin : g_body
            assign sl_a[k]  = a_q[k-1][k*SEG +: SEG];
            assign sl_b[k]  = b_q[k-1][k*SEG +: SEG];
            assign sl_ci[k] = c_q[k-1];
        end

        rca_slice #(
            .SEG(SEG)
        ) u_slice (
            .a       (sl_a[k]),
            .b       (sl_b[k]),
            .cin     (sl_ci[k]),
            .s       (sl_s[k]),
            .cout    (sl_co[k]),
            .msb_cin (sl_mc[k])
        );
    end

    assign advance   = !vld_q[LAST] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[LAST];
    assign sum       = res_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = c_q[LAST] ^ msb_c_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
                c_q[k]   <= 1'b0;
            end
            msb_c_q <= 1'b0;
        end else if (advance) begin
            // Bubbles still move data; only the valid bit marks a real beat.
            vld_q[0] <= in_valid;
            a_q[0]   <= a;
            b_q[0]   <= b_eff;
            res_q[0] <= WIDTH'(sl_s[0]);
            c_q[0]   <= sl_co[0];
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k]                 <= vld_q[k-1];
                a_q[k]                   <= a_q[k-1];
                b_q[k]                   <= b_q[k-1];
                c_q[k]                   <= sl_co[k];
                res_q[k]                 <= res_q[k-1];
                res_q[k][k*SEG +: SEG]   <= sl_s[k];
            end
            msb_c_q <= sl_mc[LAST];
        end
    end

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Bench for rca_pipe_addsub: directed arithmetic corners, stall and randomized streaming
// against a plain-arithmetic reference model.
module tb_rca_pipe_addsub;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             op;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             op        = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t exp_q[$];

    rca_pipe_addsub #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    // Reference: exact integer arithmetic, signed range check for overflow.
    function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mcin, input logic mop);
        res_t   r;
        longint full, sres, sa, sb;
        longint smax, smin;
        smax = (longint'(1) << (WIDTH - 1)) - 1;
        smin = -(longint'(1) << (WIDTH - 1));
        sa   = longint'($signed(ma));
        sb   = longint'($signed(mb));
        if (mop == 1'b0) begin
            full   = longint'(ma) + longint'(mb) + longint'(mcin);
            sres   = sa + sb + longint'(mcin);
            r.cout = (full >= (longint'(1) << WIDTH));
        end else begin
            full   = longint'(ma) - longint'(mb) - longint'(mcin);
            sres   = sa - sb - longint'(mcin);
            r.cout = (full >= 0);
        end
        r.sum = full[WIDTH-1:0];
        r.ovf = (sres > smax) || (sres < smin);
        return r;
    endfunction

    task automatic issue_and_wait(input vec_t v, output int lat);
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; op = v.op;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drive_beats(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int guard;
            @(negedge clk);
            while (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
            op  = 1'($urandom);
            in_valid = 1'b1;
            #1;
            guard = 0;
            while (!in_ready && guard < 500) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard >= 500) begin
                n_cmp++; n_err++;
                $display("FAIL drive_timeout: beat %0d in_ready=%b, want 1", i, in_ready);
            end
            exp_q.push_back(model(a, b, cin, op));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic consume(input int n, input int ready_pct, input bit stall, input int budget);
        int   got = 0;
        int   cyc = 0;
        int   stall_left = 0;
        bit   stalled = 0;
        res_t e;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (stall && !stalled && out_valid) begin
                stalled    = 1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                #1;
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready: got %b, want 0", in_ready);
                end
                n_cmp++;
                if (exp_q.size() == 0 || {out_valid, sum, cout, ovf} !== {1'b1, exp_q[0]}) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b sum=%h cout=%b ovf=%b, want head of %0d queued",
                             out_valid, sum, cout, ovf, exp_q.size());
                end
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: sum=%h with no beat outstanding", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, ovf} !== e) begin
                        n_err++;
                        $display("FAIL result[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                 got, sum, cout, ovf, e.sum, e.cout, e.ovf);
                    end
                end
                got++;
            end
        end
        n_cmp++;
        if (got != n) begin
            n_err++;
            $display("FAIL beat_count: got %0d results, want %0d", got, n);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b sum=%h cout=%b ovf=%b rdy=%b, want 0 0000 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = WIDTH'(16'h1111 * (i + 1)); b = 16'h0101; cin = 1'b0; op = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        a = 16'h4242;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL midstream_reset_state: got v=%b sum=%h cout=%b ovf=%b rdy=%b, want 0 0000 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL flushed_beats: got %0d valid cycles, want 0", seen);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_add_wrap();
        vec_t v[2];
        int   lat;
        v[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        v[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            issue_and_wait(v[i], lat);
            n_cmp++;
            if (lat != STAGES - 1) begin
                n_err++;
                $display("FAIL add_wrap_latency[%0d]: got %0d cycles, want %0d", i, lat, STAGES - 1);
            end
            n_cmp++;
            if ({out_valid, sum, cout, ovf} !== {1'b1, v[i].sum, v[i].cout, v[i].ovf}) begin
                n_err++;
                $display("FAIL add_wrap[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, sum, cout, ovf, v[i].sum, v[i].cout, v[i].ovf);
            end
        end
    endtask

    task automatic test_signed_ovf();
        vec_t v[2];
        int   lat;
        v[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            issue_and_wait(v[i], lat);
            n_cmp++;
            if (lat != STAGES - 1) begin
                n_err++;
                $display("FAIL ovf_latency[%0d]: got %0d cycles, want %0d", i, lat, STAGES - 1);
            end
            n_cmp++;
            if ({out_valid, sum, cout, ovf} !== {1'b1, v[i].sum, v[i].cout, v[i].ovf}) begin
                n_err++;
                $display("FAIL signed_ovf[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, sum, cout, ovf, v[i].sum, v[i].cout, v[i].ovf);
            end
        end
    endtask

    task automatic test_sub_borrow();
        vec_t v[2];
        int   lat;
        v[0] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        v[1] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            issue_and_wait(v[i], lat);
            n_cmp++;
            if (lat != STAGES - 1) begin
                n_err++;
                $display("FAIL sub_latency[%0d]: got %0d cycles, want %0d", i, lat, STAGES - 1);
            end
            n_cmp++;
            if ({out_valid, sum, cout, ovf} !== {1'b1, v[i].sum, v[i].cout, v[i].ovf}) begin
                n_err++;
                $display("FAIL sub_borrow[%0d]: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                         i, sum, cout, ovf, v[i].sum, v[i].cout, v[i].ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        int extra;
        exp_q.delete();
        fork
            drive_beats(6, 1'b0);
            consume(6, 100, 1'b1, 200);
        join
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_cmp++;
        if (extra != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL backpressure_drain: got %0d extra valid cycles, %0d unmatched, want 0 and 0",
                     extra, exp_q.size());
        end
    endtask

    task automatic test_random();
        exp_q.delete();
        fork
            drive_beats(1000, 1'b1);
            consume(1000, 70, 1'b0, 20000);
        join
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: got %0d unmatched beats, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_signed_ovf();
        test_sub_borrow();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
